// File: rtl/seq_frame_tx_if.sv
// seq_frame_tx_if: producer handshake plus serial output bundle for seq_frame_tx
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic valid;
  logic ready;
  logic x;
  logic busy;
  logic done;
  modport master (output data_in, valid, input ready, x, busy, done);
  modport slave (input data_in, valid, output ready, x, busy, done);
endinterface

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial framer emitting sync 1011, MSB-first payload, optional even parity, zero gap
module seq_frame_tx #(
  parameter int DATA_W = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter int GAP_BITS = 2
) (
  input logic clk,
  input logic reset,
  seq_frame_tx_if.slave bus
);
  localparam int M1 = DATA_W > 4 ? DATA_W : 4;
  localparam int CMAX = GAP_BITS > M1 ? GAP_BITS : M1;
  localparam int CW = $clog2(CMAX);
  localparam logic [3:0] SYNC_PAT = 4'b1011;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic par_q, par_d, x_q, x_d, done_q, done_d;
  assign bus.ready = (state_q == IDLE) && !reset;
  assign bus.busy = state_q != IDLE;
  assign bus.x = x_q;
  assign bus.done = done_q;
  // state_q/cn_q name the bit currently on x; next values pick the following bit
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    sh_d = sh_q;
    par_d = par_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.valid && bus.ready) begin
          state_d = SYNC;
          sh_d = bus.data_in;
          par_d = ^bus.data_in;
        end
      end
      SYNC: if (cnt_q == CW'(3)) begin
        state_d = DATA;
        cnt_d = '0;
      end
      DATA: if (cnt_q == CW'(DATA_W - 1)) begin
        if (PARITY_EN) state_d = PAR;
        else state_d = GAP;
        cnt_d = '0;
      end
      PAR: begin
        state_d = GAP;
        cnt_d = '0;
      end
      GAP: if (cnt_q == CW'(GAP_BITS - 1)) begin
        state_d = IDLE;
        cnt_d = '0;
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
    if (state_d == DATA) sh_d = sh_q << 1;
    x_d = state_d == SYNC ? SYNC_PAT[~cnt_d[1:0]] :
          state_d == DATA ? sh_q[DATA_W-1] :
          state_d == PAR ? par_q : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      x_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      par_q <= par_d;
      x_q <= x_d;
      done_q <= done_d;
    end
  end
endmodule
